// File: rtl/accum_arbiter.sv
// ---------------------------------------------------------------------------
// accum_arbiter
//
// Two requesters share one N-bit accumulator. A round-robin arbiter grants
// the accumulator to one requester. The owner then streams Len samples, each
// qualified by its Valid. The wrapped sum of the burst is reported on Q with
// a one-cycle Done pulse tagged by DoneId. If the owner drops Req mid-burst,
// the burst aborts silently and Q keeps its previous value.
//
// Ports
//   i_clk              clock, all state changes on the rising edge
//   i_reset            asynchronous active-high reset
//   i_req0/i_req1      request, held high for the whole burst
//   i_len0/i_len1      burst sample count, sampled at grant
//   i_data0/i_data1    sample data
//   i_valid0/i_valid1  sample qualifier
//   o_gnt0/o_gnt1      registered grant, one-hot or zero
//   o_q                registered sum of the last completed burst
//   o_done             one-cycle pulse when o_q is updated
//   o_done_id          owner of the burst reported by o_done
// ---------------------------------------------------------------------------
module accum_arbiter #(
  parameter int N = 6,
  parameter int L = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_req0,
  input  logic         i_req1,
  input  logic [L-1:0] i_len0,
  input  logic [L-1:0] i_len1,
  input  logic [N-1:0] i_data0,
  input  logic [N-1:0] i_data1,
  input  logic         i_valid0,
  input  logic         i_valid1,
  output logic         o_gnt0,
  output logic         o_gnt1,
  output logic [N-1:0] o_q,
  output logic         o_done,
  output logic         o_done_id
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t       r_state;
  logic         r_gnt0;
  logic         r_gnt1;
  logic         r_owner;    // 0 = requester 0, 1 = requester 1
  logic         r_last;     // last-served pointer
  logic [N-1:0] r_acc;
  logic [L-1:0] r_cnt;
  logic [N-1:0] r_q;
  logic         r_done;
  logic         r_done_id;

  // Arbitration: a lone requester wins; on a tie the one not served last wins.
  logic         w_winner;
  logic [L-1:0] w_win_len;
  logic         w_own_req;
  logic         w_own_valid;
  logic [N-1:0] w_own_data;
  logic [N-1:0] w_sum;

  assign w_winner    = (i_req0 & i_req1) ? ~r_last : i_req1;
  assign w_win_len   = w_winner ? i_len1 : i_len0;
  assign w_own_req   = r_owner ? i_req1   : i_req0;
  assign w_own_valid = r_owner ? i_valid1 : i_valid0;
  assign w_own_data  = r_owner ? i_data1  : i_data0;
  // Sum truncates to N bits, so overflow wraps modulo 2^N.
  assign w_sum       = r_acc + w_own_data;

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others, whatever the order
  // of statements inside this block.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_owner   <= 1'b0;
      r_last    <= 1'b1;   // requester 0 wins the first tie
      r_acc     <= '0;
      r_cnt     <= '0;
      r_q       <= '0;
      r_done    <= 1'b0;
      r_done_id <= 1'b0;
    end else begin
      // NOTE: Done defaults low every edge; only the completing edge raises
      // it, which makes it a one-cycle pulse without a separate clear path.
      r_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (i_req0 | i_req1) begin
            r_owner <= w_winner;
            r_last  <= w_winner;
            r_gnt0  <= ~w_winner;
            r_gnt1  <= w_winner;
            r_acc   <= '0;
            r_cnt   <= w_win_len;
            // A zero-length burst has nothing to accumulate.
            r_state <= (w_win_len == '0) ? S_FINISH : S_ACCUM;
          end
        end

        S_ACCUM: begin
          if (!w_own_req) begin
            // Abort: drop the grant, leave Q untouched, no Done.
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_own_valid) begin
            r_acc <= w_sum;
            if (r_cnt == L'(1)) begin
              r_q       <= w_sum;
              r_done    <= 1'b1;
              r_done_id <= r_owner;
              r_gnt0    <= 1'b0;
              r_gnt1    <= 1'b0;
              r_state   <= S_FINISH;
            end else begin
              r_cnt <= r_cnt - L'(1);
            end
          end
        end

        S_FINISH: begin
          // Grant still held here only for a zero-length burst: report its
          // empty sum now, one edge after the grant.
          if (r_gnt0 | r_gnt1) begin
            r_q       <= r_acc;
            r_done    <= 1'b1;
            r_done_id <= r_owner;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
          end
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_gnt0    = r_gnt0;
  assign o_gnt1    = r_gnt1;
  assign o_q       = r_q;
  assign o_done    = r_done;
  assign o_done_id = r_done_id;

endmodule

// File: tb/tb_accum_arbiter.sv
// ---------------------------------------------------------------------------
// tb_accum_arbiter
//
// Directed bench for accum_arbiter (N=6, L=4). Inputs change 1 time unit
// after each rising edge, and outputs are sampled at the same point, well
// away from the next edge. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_accum_arbiter;

  localparam int N = 6;
  localparam int L = 4;

  logic         clk;
  logic         rst;
  logic         req0, req1;
  logic [L-1:0] len0, len1;
  logic [N-1:0] data0, data1;
  logic         valid0, valid1;
  logic         gnt0, gnt1;
  logic [N-1:0] q;
  logic         done;
  logic         done_id;

  int n_vec = 0;
  int n_err = 0;

  accum_arbiter #(.N(N), .L(L)) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_req0    (req0),
    .i_req1    (req1),
    .i_len0    (len0),
    .i_len1    (len1),
    .i_data0   (data0),
    .i_data1   (data1),
    .i_valid0  (valid0),
    .i_valid1  (valid1),
    .o_gnt0    (gnt0),
    .o_gnt1    (gnt1),
    .o_q       (q),
    .o_done    (done),
    .o_done_id (done_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    len0 = '0;   len1 = '0;
    data0 = '0;  data1 = '0;
    valid0 = 1'b0; valid1 = 1'b0;

    // Reset state
    #3;
    check("rst_gnt0", gnt0, 0);
    check("rst_gnt1", gnt1, 0);
    check("rst_q", q, 0);
    check("rst_done", done, 0);
    check("rst_done_id", done_id, 0);
    tick();
    tick();
    rst = 1'b0;

    // Zero-length burst: Done one edge after grant, Q = 0
    req0 = 1'b1; len0 = 4'd0;
    tick();
    check("len0_gnt0", gnt0, 1);
    check("len0_no_done_at_grant", done, 0);
    tick();
    check("len0_done", done, 1);
    check("len0_q", q, 0);
    check("len0_done_id", done_id, 0);
    check("len0_gnt0_off", gnt0, 0);
    req0 = 1'b0;
    tick();
    check("len0_done_pulse", done, 0);

    // Burst 2+4+7 = 13; Len changed after grant has no effect
    req0 = 1'b1; len0 = 4'd3;
    tick();
    check("b13_gnt0", gnt0, 1);
    check("b13_gnt1", gnt1, 0);
    len0 = 4'd1;
    data0 = 6'd2; valid0 = 1'b1;
    tick();
    data0 = 6'd4;
    tick();
    check("b13_no_early_done", done, 0);
    data0 = 6'd7;
    tick();
    check("b13_done", done, 1);
    check("b13_q", q, 13);
    check("b13_done_id", done_id, 0);
    check("b13_gnt0_off", gnt0, 0);
    req0 = 1'b0; valid0 = 1'b0;
    tick();
    check("b13_done_pulse", done, 0);
    check("b13_q_hold", q, 13);

    // Req1 alone, 63 + 2 wraps to 1, 3-cycle Valid gap; non-owner noise ignored
    req1 = 1'b1; len1 = 4'd2;
    tick();
    check("wrap_gnt1", gnt1, 1);
    check("wrap_gnt0", gnt0, 0);
    data1 = 6'd63; valid1 = 1'b1;
    data0 = 6'd9;  valid0 = 1'b1;
    tick();
    valid1 = 1'b0;
    tick();
    tick();
    tick();
    check("wrap_no_done_in_gap", done, 0);
    check("wrap_gnt1_in_gap", gnt1, 1);
    data1 = 6'd2; valid1 = 1'b1;
    tick();
    check("wrap_done", done, 1);
    check("wrap_q", q, 1);
    check("wrap_done_id", done_id, 1);
    req1 = 1'b0; valid1 = 1'b0; valid0 = 1'b0;
    tick();

    // Abort: Req0 dropped after 1 of 3 samples; Req1 pending then served
    req0 = 1'b1; len0 = 4'd3;
    req1 = 1'b1; len1 = 4'd1;
    tick();
    check("abort_gnt0", gnt0, 1);
    check("abort_gnt1_pending", gnt1, 0);
    data0 = 6'd10; valid0 = 1'b1;
    data1 = 6'd20; valid1 = 1'b1;
    tick();
    req0 = 1'b0; valid0 = 1'b0;
    tick();
    check("abort_gnt0_off", gnt0, 0);
    check("abort_gnt1_idle", gnt1, 0);
    check("abort_no_done", done, 0);
    check("abort_q_hold", q, 1);
    tick();
    check("abort_then_gnt1", gnt1, 1);
    tick();
    check("abort_r1_done", done, 1);
    check("abort_r1_q", q, 20);
    check("abort_r1_done_id", done_id, 1);
    req1 = 1'b0; valid1 = 1'b0;
    tick();

    // Reset mid-burst between edges: outputs clear before the next edge
    req0 = 1'b1; len0 = 4'd3; data0 = 6'd5;
    tick();
    check("mid_gnt0", gnt0, 1);
    valid0 = 1'b1;
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("async_gnt0", gnt0, 0);
    check("async_q", q, 0);
    check("async_done", done, 0);
    req0 = 1'b1; req1 = 1'b1;
    len0 = 4'd1; len1 = 4'd1;
    data0 = 6'd3; data1 = 6'd4;
    valid0 = 1'b1; valid1 = 1'b1;
    tick();
    check("rst_hold_done", done, 0);
    rst = 1'b0;

    // Continuous tie, Len=1: grants alternate 0,1,0,1 with matching DoneId
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rr_gnt0", gnt0, (i % 2 == 0) ? 1 : 0);
      check("rr_gnt1", gnt1, (i % 2 == 0) ? 0 : 1);
      tick();
      check("rr_done", done, 1);
      check("rr_done_id", done_id, (i % 2 == 0) ? 0 : 1);
      check("rr_q", q, (i % 2 == 0) ? 3 : 4);
      check("rr_gnt_off", {gnt0, gnt1}, 0);
      tick();
      check("rr_gap_done", done, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
